counter_sequencer: RTL and testbench

- Sequencing controller for the 4-bit synchronous BCD counter that drives the seven-segment decoder.
- Replaces the free-running count with a state machine supporting run/stop, up/down direction, parallel load and one-shot mode.
- Presents the count on W,X,Y,Z (W = MSB) so it drops straight into the existing board top in place of the free-running counter.
- Exposes a terminal-count pulse and its state for LEDs or cascading.

---
 rtl/counter_pkg.sv | 8 +
 rtl/count_step.sv | 18 +
 rtl/counter_sequencer.sv | 65 ++++++
 tb/tb_counter_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state encodings and count width for the BCD counter sequencer
package counter_pkg;
  localparam int COUNT_W = 4;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;
endpackage

// File: rtl/count_step.sv
// count_step: next up/down count value with wrap, plus terminal-value detect
module count_step
  import counter_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MAX_VAL = 4'd9
) (
  input  logic [COUNT_W-1:0] count,
  input  logic               dir,
  output logic [COUNT_W-1:0] next,
  output logic               at_terminal
);
  // Out-of-range counts recover to 0 going up and MAX_VAL going down
  always_comb begin
    at_terminal = dir ? (count == MAX_VAL) : (count == '0);
    next = dir ? ((count >= MAX_VAL) ? '0 : count + 1'b1)
               : ((count == '0 || count > MAX_VAL) ? MAX_VAL : count - 1'b1);
  end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: run/stop, up/down, load and one-shot sequencing for a BCD counter
module counter_sequencer
  import counter_pkg::*;
#(
  parameter logic [COUNT_W-1:0] MAX_VAL = 4'd9
) (
  input  logic               KEY_3,
  input  logic               SW17,
  input  logic               SW_RUN,
  input  logic               SW_DIR,
  input  logic               SW_LOAD,
  input  logic               SW_MODE,
  input  logic [COUNT_W-1:0] LOAD_VAL,
  output logic               W,
  output logic               X,
  output logic               Y,
  output logic               Z,
  output logic               TC,
  output logic [1:0]         STATE
);
  logic [1:0]         state;
  logic [COUNT_W-1:0] count;
  logic               tc;
  logic [COUNT_W-1:0] next;
  logic [COUNT_W-1:0] clamp;
  logic               at_terminal;
  count_step #(.MAX_VAL(MAX_VAL)) u_step (
    .count(count),
    .dir(SW_DIR),
    .next(next),
    .at_terminal(at_terminal)
  );
  assign clamp = (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;
  always_ff @(posedge KEY_3 or negedge SW17) begin
    if (!SW17) begin
      state <= ST_IDLE;
      count <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        ST_IDLE: state <= SW_LOAD ? ST_LOAD : (SW_RUN ? ST_RUN : ST_IDLE);
        ST_LOAD: begin
          count <= clamp;
          state <= SW_LOAD ? ST_LOAD : ST_IDLE;
        end
        ST_RUN: begin
          if (SW_LOAD) state <= ST_LOAD;
          else if (!SW_RUN) state <= ST_IDLE;
          else if (SW_MODE && at_terminal) begin
            tc    <= 1'b1;
            state <= ST_DONE;
          end else begin
            count <= next;
            tc    <= at_terminal;
          end
        end
        default: state <= SW_LOAD ? ST_LOAD : (SW_RUN ? ST_DONE : ST_IDLE);
      endcase
    end
  end
  assign {W, X, Y, Z} = count;
  assign TC = tc;
  assign STATE = state;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed vector table plus async-reset sequence for counter_sequencer
module tb_counter_sequencer;
  typedef struct {
    logic       run, dir, load, mode;
    logic [3:0] lval;
    logic [3:0] cnt;
    logic [1:0] st;
    logic       tc;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0, dir = 1'b1, load = 1'b0, mode = 1'b0;
  logic [3:0] lval = 4'd0;
  logic       w, x, y, z, tc;
  logic [1:0] st;
  int         tests = 0;
  int         fails = 0;
  vec_t       vecs[$];
  counter_sequencer #(.MAX_VAL(4'd9)) dut (
    .KEY_3(clk),
    .SW17(rst_n),
    .SW_RUN(run),
    .SW_DIR(dir),
    .SW_LOAD(load),
    .SW_MODE(mode),
    .LOAD_VAL(lval),
    .W(w),
    .X(x),
    .Y(y),
    .Z(z),
    .TC(tc),
    .STATE(st)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input logic r, d, l, m, input logic [3:0] lv,
                             input logic [3:0] c, input logic [1:0] s, input logic t);
    vec_t e;
    e.run = r; e.dir = d; e.load = l; e.mode = m; e.lval = lv;
    e.cnt = c; e.st = s; e.tc = t;
    return e;
  endfunction
  task automatic check(input string name, input logic [3:0] c, input logic [1:0] s, input logic t);
    tests++;
    if ({w, x, y, z} !== c || st !== s || tc !== t) begin
      fails++;
      $display("FAIL %s: got count=%0d state=%b tc=%b, want count=%0d state=%b tc=%b",
               name, {w, x, y, z}, st, tc, c, s, t);
    end
  endtask
  task automatic step(input logic r, d, l, m, input logic [3:0] lv);
    run = r; dir = d; load = l; mode = m; lval = lv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // up count from reset: IDLE->RUN edge holds 0, then 1..9,0,1 with TC on the wrap
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 2'b01, 0));
    for (int i = 1; i <= 9; i++) vecs.push_back(v(1, 1, 0, 0, 0, 4'(i), 2'b01, 0));
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 2'b01, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 1, 2'b01, 0));
    // down through the 0->9 wrap
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 9, 2'b01, 1));
    vecs.push_back(v(1, 0, 0, 0, 0, 8, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 7, 2'b01, 0));
    // load 13 saturates to 9
    vecs.push_back(v(1, 0, 1, 0, 13, 7, 2'b10, 0));
    vecs.push_back(v(1, 0, 1, 0, 13, 9, 2'b10, 0));
    vecs.push_back(v(0, 0, 0, 0, 13, 9, 2'b00, 0));
    vecs.push_back(v(0, 0, 0, 0, 13, 9, 2'b00, 0));
    // one-shot up from 7
    vecs.push_back(v(0, 1, 1, 1, 7, 9, 2'b10, 0));
    vecs.push_back(v(0, 1, 1, 1, 7, 7, 2'b10, 0));
    vecs.push_back(v(0, 1, 0, 1, 7, 7, 2'b00, 0));
    vecs.push_back(v(1, 1, 0, 1, 7, 7, 2'b01, 0));
    vecs.push_back(v(1, 1, 0, 1, 7, 8, 2'b01, 0));
    vecs.push_back(v(1, 1, 0, 1, 7, 9, 2'b01, 0));
    vecs.push_back(v(1, 1, 0, 1, 7, 9, 2'b11, 1));
    vecs.push_back(v(1, 1, 0, 1, 7, 9, 2'b11, 0));
    vecs.push_back(v(1, 0, 0, 1, 7, 9, 2'b11, 0));
    vecs.push_back(v(0, 0, 0, 1, 7, 9, 2'b00, 0));
    // continuous up to 5, LOAD beats RUN, then DIR flip at 5
    vecs.push_back(v(1, 1, 0, 0, 5, 9, 2'b01, 0));
    vecs.push_back(v(1, 1, 0, 0, 5, 0, 2'b01, 1));
    for (int i = 1; i <= 5; i++) vecs.push_back(v(1, 1, 0, 0, 5, 4'(i), 2'b01, 0));
    vecs.push_back(v(1, 1, 1, 0, 5, 5, 2'b10, 0));
    vecs.push_back(v(1, 1, 1, 0, 5, 5, 2'b10, 0));
    vecs.push_back(v(1, 1, 0, 0, 5, 5, 2'b00, 0));
    vecs.push_back(v(1, 1, 0, 0, 5, 5, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 0, 5, 4, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 0, 5, 3, 2'b01, 0));
    // one-shot down stops at 0
    vecs.push_back(v(1, 0, 0, 1, 5, 2, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 1, 5, 1, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 1, 5, 0, 2'b01, 0));
    vecs.push_back(v(1, 0, 0, 1, 5, 0, 2'b11, 1));
    vecs.push_back(v(1, 0, 1, 1, 3, 0, 2'b10, 0));
    vecs.push_back(v(1, 0, 0, 1, 3, 3, 2'b00, 0));
    #12;
    check("reset_hold", 0, 2'b00, 0);
    step(1, 1, 0, 0, 0);
    check("reset_held_edge", 0, 2'b00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].run, vecs[i].dir, vecs[i].load, vecs[i].mode, vecs[i].lval);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].st, vecs[i].tc);
    end
    // async reset mid-run at count 6
    step(1, 1, 0, 0, 0);
    check("ar_run", 3, 2'b01, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("ar_at6", 6, 2'b01, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_immediate", 0, 2'b00, 0);
    step(1, 1, 0, 0, 0);
    check("ar_held1", 0, 2'b00, 0);
    step(1, 1, 0, 0, 0);
    check("ar_held2", 0, 2'b00, 0);
    #2;
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0);
    check("ar_resume_run", 0, 2'b01, 0);
    step(1, 1, 0, 0, 0);
    check("ar_resume_step", 1, 2'b01, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
